mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register of the SIMD AES pipeline. Consumes the MEM_* bundle produced by the EX/MEM register, performs scalar (32-bit) and vector (128-bit, four-beat) loads and stores against a single-port synchronous data memory, and registers results into the WB_* bundle for register-file writeback. Multi-cycle accesses are sequenced by an FSM that raises `stall` so that upstream stages hold the MEM_* inputs.

---
 rtl/mem_wb_stage_pkg.sv | 42 ++++
 rtl/mem_wb_reg.sv | 35 +++
 rtl/mem_wb_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared types, widths and helpers for the memory-access / writeback stage
// of the SIMD AES pipeline.
package mem_wb_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned VLEN   = 128;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned BEATS  = VLEN / DATA_W;
  localparam int unsigned BEAT_W = $clog2(BEATS);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SLOAD,
    VLOAD,
    VLAST,
    VSTORE
  } state_e;

  // Writeback payload carried by the MEM/WB register.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [VLEN-1:0]   vresult;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
    logic              vreg_write;
  } wb_bundle_t;

  // Extract 32-bit lane idx of a vector (lane i = bits [32i+31:32i]).
  function automatic logic [DATA_W-1:0] lane_sel(input logic [VLEN-1:0]   v,
                                                 input logic [BEAT_W-1:0] idx);
    return v[DATA_W*idx +: DATA_W];
  endfunction

  // Byte address of beat idx relative to a base; wraps modulo 2^32.
  function automatic logic [DATA_W-1:0] beat_addr(input logic [DATA_W-1:0] base,
                                                  input logic [BEAT_W-1:0] idx);
    return base + (DATA_W'(idx) << 2);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the writeback bundle, inserts a bubble
// (write enables cleared, payload held) while the stage is stalled.
module mem_wb_reg
  import mem_wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       bubble,
  input  logic       res_en,
  input  logic       vres_en,
  input  wb_bundle_t d,
  output wb_bundle_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q.reg_write  <= 1'b0;
      q.vreg_write <= 1'b0;
    end else if (en) begin
      if (res_en) begin
        q.result <= d.result;
      end
      if (vres_en) begin
        q.vresult <= d.vresult;
      end
      q.rd         <= d.rd;
      q.reg_write  <= d.reg_write;
      q.vreg_write <= d.vreg_write;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB register: scalar and four-beat vector
// loads/stores over a single-port synchronous data memory.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] MEM_ALUResult,
  input  logic [DATA_W-1:0] MEM_WriteData,
  input  logic [VLEN-1:0]   MEM_VWriteData,
  input  logic [RD_W-1:0]   MEM_rd,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemToReg,
  input  logic              MEM_MemWrite,
  input  logic              MEM_VRegWrite,
  input  logic              MEM_VMem,
  output logic [DATA_W-1:0] dmem_addr,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] WB_Result,
  output logic [VLEN-1:0]   WB_VResult,
  output logic [RD_W-1:0]   WB_rd,
  output logic              WB_RegWrite,
  output logic              WB_VRegWrite
);

  state_e            state, state_d;
  logic [BEAT_W-1:0] beat, beat_d;
  logic [BEAT_W-1:0] prev_beat;
  logic [DATA_W-1:0] base, base_d;
  logic [VLEN-1:0]   vbuf, vbuf_d;
  logic              is_load;
  logic              is_store;
  logic              res_en;
  logic              vres_en;
  wb_bundle_t        wb_d;
  wb_bundle_t        wb_q;

  // MemToReg wins when both MemToReg and MemWrite are set.
  assign is_load   = MEM_MemToReg;
  assign is_store  = MEM_MemWrite & ~MEM_MemToReg;
  assign prev_beat = beat - BEAT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      base  <= '0;
      vbuf  <= '0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
      base  <= base_d;
      vbuf  <= vbuf_d;
    end
  end

  // Next state, beat counter, latched base and vector buffer.
  always_comb begin
    state_d = state;
    beat_d  = beat;
    base_d  = base;
    vbuf_d  = vbuf;
    unique case (state)
      IDLE: begin
        if (is_load && MEM_VMem) begin
          state_d = VLOAD;
          beat_d  = BEAT_W'(1);
          base_d  = MEM_ALUResult;
        end else if (is_load) begin
          state_d = SLOAD;
        end else if (is_store && MEM_VMem) begin
          state_d = VSTORE;
          beat_d  = BEAT_W'(1);
          base_d  = MEM_ALUResult;
          vbuf_d  = MEM_VWriteData;
        end
      end
      SLOAD: begin
        state_d = IDLE;
      end
      VLOAD: begin
        // Word returned for the previous beat lands in its lane.
        vbuf_d[DATA_W*prev_beat +: DATA_W] = dmem_rdata;
        beat_d = beat + BEAT_W'(1);
        if (beat == LAST_BEAT) begin
          state_d = VLAST;
          beat_d  = '0;
        end
      end
      VLAST: begin
        state_d = IDLE;
      end
      VSTORE: begin
        beat_d = beat + BEAT_W'(1);
        if (beat == LAST_BEAT) begin
          state_d = IDLE;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Memory strobes and stall; forced low while reset is asserted.
  always_comb begin
    stall      = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = MEM_ALUResult;
    dmem_wdata = MEM_WriteData;
    unique case (state)
      IDLE: begin
        if (is_load) begin
          dmem_re = 1'b1;
          stall   = 1'b1;
        end else if (is_store) begin
          dmem_we = 1'b1;
          if (MEM_VMem) begin
            dmem_wdata = lane_sel(MEM_VWriteData, BEAT_W'(0));
            stall      = 1'b1;
          end
        end
      end
      VLOAD: begin
        dmem_re   = 1'b1;
        dmem_addr = beat_addr(base, beat);
        stall     = 1'b1;
      end
      VSTORE: begin
        dmem_we    = 1'b1;
        dmem_addr  = beat_addr(base, beat);
        dmem_wdata = lane_sel(vbuf, beat);
        stall      = (beat != LAST_BEAT);
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    if (!rst_n) begin
      stall   = 1'b0;
      dmem_re = 1'b0;
      dmem_we = 1'b0;
    end
  end

  // Writeback payload selection.
  always_comb begin
    wb_d            = '0;
    wb_d.result     = (state == SLOAD) ? dmem_rdata : MEM_ALUResult;
    wb_d.vresult    = {dmem_rdata, vbuf[VLEN-DATA_W-1:0]};
    wb_d.rd         = MEM_rd;
    wb_d.reg_write  = MEM_RegWrite;
    wb_d.vreg_write = MEM_VRegWrite;
    res_en          = (state != VLAST);
    vres_en         = (state == VLAST);
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (~stall),
    .bubble  (stall),
    .res_en  (res_en),
    .vres_en (vres_en),
    .d       (wb_d),
    .q       (wb_q)
  );

  assign WB_Result    = wb_q.result;
  assign WB_VResult   = wb_q.vresult;
  assign WB_rd        = wb_q.rd;
  assign WB_RegWrite  = wb_q.reg_write;
  assign WB_VRegWrite = wb_q.vreg_write;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage with a behavioural synchronous memory.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [31:0]       MEM_ALUResult;
  logic [31:0]       MEM_WriteData;
  logic [127:0]      MEM_VWriteData;
  logic [4:0]        MEM_rd;
  logic              MEM_RegWrite, MEM_MemToReg, MEM_MemWrite, MEM_VRegWrite, MEM_VMem;
  logic [31:0]       dmem_addr;
  logic              dmem_re, dmem_we;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              stall;
  logic [31:0]       WB_Result;
  logic [127:0]      WB_VResult;
  logic [4:0]        WB_rd;
  logic              WB_RegWrite, WB_VRegWrite;

  mem_wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MEM_ALUResult  (MEM_ALUResult),
    .MEM_WriteData  (MEM_WriteData),
    .MEM_VWriteData (MEM_VWriteData),
    .MEM_rd         (MEM_rd),
    .MEM_RegWrite   (MEM_RegWrite),
    .MEM_MemToReg   (MEM_MemToReg),
    .MEM_MemWrite   (MEM_MemWrite),
    .MEM_VRegWrite  (MEM_VRegWrite),
    .MEM_VMem       (MEM_VMem),
    .dmem_addr      (dmem_addr),
    .dmem_re        (dmem_re),
    .dmem_we        (dmem_we),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .stall          (stall),
    .WB_Result      (WB_Result),
    .WB_VResult     (WB_VResult),
    .WB_rd          (WB_rd),
    .WB_RegWrite    (WB_RegWrite),
    .WB_VRegWrite   (WB_VRegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural single-port memory, read data valid the cycle after re.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rdata_q;
  int          wr_cnt = 0;
  logic [31:0] re_log [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  initial rdata_q = 32'h0;
  assign dmem_rdata = rdata_q;

  always @(posedge clk) begin
    if (dmem_we) begin
      mem[dmem_addr] = dmem_wdata;
      wr_cnt++;
    end
    if (dmem_re) begin
      rdata_q <= mem_rd(dmem_addr);
      re_log.push_back(dmem_addr);
    end
  end

  typedef struct {
    bit           is_vec;
    logic [31:0]  res;
    logic [127:0] vres;
    logic [4:0]   rd;
  } exp_t;
  exp_t exp_q [$];

  task automatic expect_s(input logic [31:0] res, input logic [4:0] rd);
    exp_t e;
    e.is_vec = 1'b0; e.res = res; e.vres = '0; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic expect_v(input logic [127:0] vres, input logic [4:0] rd);
    exp_t e;
    e.is_vec = 1'b1; e.res = '0; e.vres = vres; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: every writeback strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && (WB_RegWrite || WB_VRegWrite)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", 128'({WB_RegWrite, WB_VRegWrite}), 128'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 128'(WB_rd), 128'(e.rd));
        if (e.is_vec) begin
          chk("wb_vresult", WB_VResult, e.vres);
          chk("wb_vregwrite", 128'({WB_RegWrite, WB_VRegWrite}), 128'(2'b01));
        end else begin
          chk("wb_result", 128'(WB_Result), 128'(e.res));
          chk("wb_regwrite", 128'({WB_RegWrite, WB_VRegWrite}), 128'(2'b10));
        end
      end
    end
  end

  task automatic nop();
    MEM_ALUResult  = '0;
    MEM_WriteData  = '0;
    MEM_VWriteData = '0;
    MEM_rd         = '0;
    MEM_RegWrite   = 1'b0;
    MEM_MemToReg   = 1'b0;
    MEM_MemWrite   = 1'b0;
    MEM_VRegWrite  = 1'b0;
    MEM_VMem       = 1'b0;
  endtask

  // Issue one op at a falling edge and hold it while stall is expected high.
  task automatic op(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                    input logic [127:0] vwd, input logic [4:0] rd,
                    input logic rw, input logic m2r, input logic mw,
                    input logic vrw, input logic vmem, input int nst);
    MEM_ALUResult  = alu;
    MEM_WriteData  = wd;
    MEM_VWriteData = vwd;
    MEM_rd         = rd;
    MEM_RegWrite   = rw;
    MEM_MemToReg   = m2r;
    MEM_MemWrite   = mw;
    MEM_VRegWrite  = vrw;
    MEM_VMem       = vmem;
    for (int c = 0; c <= nst; c++) begin
      #1;
      chk($sformatf("%s_stall_c%0d", tag, c), 128'(stall), 128'(c < nst));
      @(negedge clk);
    end
    nop();
  endtask

  localparam logic [127:0] VDATA = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] WDATA = 128'h44444444_33333333_22222222_11111111;

  initial begin
    int wr_before;
    rst_n = 1'b0;
    nop();
    #3;
    chk("rst_wb_result", 128'(WB_Result), 128'(0));
    chk("rst_wb_vresult", WB_VResult, 128'(0));
    chk("rst_wb_rd_we", 128'({WB_rd, WB_RegWrite, WB_VRegWrite}), 128'(0));
    chk("rst_strobes", 128'({stall, dmem_re, dmem_we}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    expect_s(32'h0000_1234, 5'd7);
    op("alu", 32'h0000_1234, 32'h0, '0, 5'd7, 1, 0, 0, 0, 0, 0);

    op("sst", 32'h40, 32'hDEADBEEF, '0, 5'd0, 0, 0, 1, 0, 0, 0);
    chk("sst_mem40", 128'(mem_rd(32'h40)), 128'(32'hDEADBEEF));

    expect_s(32'hDEADBEEF, 5'd3);
    op("sld", 32'h40, 32'h0, '0, 5'd3, 1, 1, 0, 0, 0, 1);

    op("vst", 32'h100, 32'h0, VDATA, 5'd0, 0, 0, 1, 0, 1, 3);
    chk("vst_mem100", 128'(mem_rd(32'h100)), 128'(32'hCCDDEEFF));
    chk("vst_mem104", 128'(mem_rd(32'h104)), 128'(32'h8899AABB));
    chk("vst_mem108", 128'(mem_rd(32'h108)), 128'(32'h44556677));
    chk("vst_mem10c", 128'(mem_rd(32'h10C)), 128'(32'h00112233));

    expect_v(VDATA, 5'd9);
    op("vld", 32'h100, 32'h0, '0, 5'd9, 0, 1, 0, 1, 1, 4);

    wr_before = wr_cnt;
    expect_s(32'hDEADBEEF, 5'd4);
    op("ldst", 32'h40, 32'h12345678, '0, 5'd4, 1, 1, 1, 0, 0, 1);
    chk("ldst_no_write", 128'(wr_cnt - wr_before), 128'(0));
    chk("ldst_mem40", 128'(mem_rd(32'h40)), 128'(32'hDEADBEEF));

    op("vst_wrap", 32'hFFFF_FFFC, 32'h0, WDATA, 5'd0, 0, 0, 1, 0, 1, 3);
    chk("wrap_mem0", 128'(mem_rd(32'h0)), 128'(32'h22222222));
    chk("wrap_mem8", 128'(mem_rd(32'h8)), 128'(32'h44444444));
    re_log.delete();
    expect_v(WDATA, 5'd10);
    op("vld_wrap", 32'hFFFF_FFFC, 32'h0, '0, 5'd10, 0, 1, 0, 1, 1, 4);
    chk("wrap_re_count", 128'(re_log.size()), 128'(4));
    if (re_log.size() == 4) begin
      chk("wrap_re0", 128'(re_log[0]), 128'(32'hFFFF_FFFC));
      chk("wrap_re1", 128'(re_log[1]), 128'(32'h0));
      chk("wrap_re2", 128'(re_log[2]), 128'(32'h4));
      chk("wrap_re3", 128'(re_log[3]), 128'(32'h8));
    end

    // Abort a vector load at beat 2 with an asynchronous reset.
    MEM_ALUResult = 32'h100; MEM_rd = 5'd11; MEM_MemToReg = 1'b1;
    MEM_VRegWrite = 1'b1;    MEM_VMem = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_pre_stall", 128'({stall, dmem_re}), 128'(2'b11));
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_stall", 128'(stall), 128'(0));
    chk("abort_re_we", 128'({dmem_re, dmem_we}), 128'(0));
    chk("abort_vregwrite", 128'(WB_VRegWrite), 128'(0));
    nop();
    @(negedge clk);
    rst_n = 1'b1;

    expect_v(VDATA, 5'd12);
    op("vld_after_rst", 32'h100, 32'h0, '0, 5'd12, 0, 1, 0, 1, 1, 4);

    op("tail", 32'h0, 32'h0, '0, 5'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
